vedic_mac_32bits: RTL and testbench
===================================

# vedic_mac_32bits

Pipelined, streaming multiply-accumulate stage placed directly downstream of `vedic_32bits`. It registers operand pairs into a `vedic_32bits` instance and registers each 64-bit product. It then sums the products of a frame of beats, delimited by `IN_LAST`, into a wide accumulator. The finished dot product is presented on a valid/ready output. It is the first clocked stage around the combinational multiplier and feeds the filter/dot-product datapath.

## Interface
- `ACC_W`, default 72: accumulator and result width. Legal range is 64 to 128.
- `CNT_W`, default 8: width of the beat counter.

- `CLK` in, 1: clock. All state updates on the rising edge.
- `RST` in, 1: synchronous, active-high reset.
- `IN_VALID` in, 1: operand beat valid.
- `IN_READY` out, 1: stage can accept a beat.
- `IN_LAST` in, 1: beat is the last of its frame.
- `A` in, 32: unsigned multiplicand.
- `B` in, 32: unsigned multiplier.
- `OUT_VALID` out, 1: frame result valid.
- `OUT_READY` in, 1: consumer accepts the result.
- `ACC` out, `ACC_W`: frame sum of A*B.
- `OUT_CNT` out, `CNT_W`: number of beats in the frame, saturating.
- `OVF` out, 1: the frame sum exceeded `ACC_W` bits.

## Operation
- **Global enable.** `en = ~(OUT_VALID & ~OUT_READY)`. Every pipeline register, the accumulator and the counters advance only when `en=1`.
- **Input handshake.** `IN_READY = en`. It is combinational from `OUT_READY`. A beat is accepted when `IN_VALID & IN_READY`.
- **S1, operand register.** On `en`, S1 loads `A_r`, `B_r`, `last1`, and `v1 <= IN_VALID`. `A_r` and `B_r` drive the `vedic_32bits` instance.
- **S2, product register.** On `en`, S2 loads `P_r <= Q` (64 bits), `last2 <= last1`, and `v2 <= v1`.
- **S3, accumulate.** On `en & v2`:
  - `sum = acc + zero-extend(P_r)`, computed in `ACC_W+1` bits.
  - The carry out of bit `ACC_W-1` sets `ovf_acc`, which is sticky within the frame.
  - `cnt` increments and saturates at 2^CNT_W−1.
- **Frame end.** When `v2 & last2`:
  - `ACC <= sum[ACC_W-1:0]`.
  - `OUT_CNT <= cnt+1`, saturating.
  - `OVF <= ovf_acc | carry`.
  - `OUT_VALID <= 1`.
  - `acc`, `cnt` and `ovf_acc` clear to 0 in the same edge, ready for the next frame.
  - Otherwise `acc <= sum` and `cnt`/`ovf_acc` update as above.
- **Output drop.** `OUT_VALID` clears on `OUT_VALID & OUT_READY` unless a new frame end is loading on that same edge, in which case the output reloads and stays high.
- **Bubbles.** `v*=0` stages do not touch `acc` or `cnt`. Gaps inside a frame are legal.
- **Frame length.** A frame of one beat yields `ACC = A*B`. Frames have no minimum or maximum length. `OUT_CNT` saturates.
- **Arithmetic.** All arithmetic is unsigned, and `ACC_W=64` is permitted.
- **Reset.** `RST` clears:
  - `v1`, `v2` and `OUT_VALID` to 0.
  - `acc`, `cnt` and `ovf_acc` to 0.
  - `ACC`, `OUT_CNT` and `OVF` to 0.
  
  `A_r`, `B_r` and `P_r` also clear to 0. A partial frame in flight is discarded. `RST` overrides `en`.

## Timing
- Beat accepted at the edge ending cycle 0 → in S1 during cycle 1, in S2 during cycle 2, accumulated at the edge ending cycle 2.
- A last beat accepted in cycle 0 gives `OUT_VALID=1` in cycle 3. Latency is 3 cycles.
- Throughput is one beat per cycle. Back-to-back frames, including consecutive single-beat frames, produce one result per cycle when `OUT_READY=1`.
- **Backpressure.** While `OUT_VALID=1` and `OUT_READY=0`, the entire pipeline freezes:
  - `IN_READY=0`.
  - `ACC`, `OUT_CNT` and `OVF` stay stable.
  - No beat is lost or duplicated.
- The critical path is the `vedic_32bits` instance between S1 and S2. The `ACC_W`-bit adder sits alone in S3.

## Test plan
- **Single beat, maximum operands.** `A=B=0xFFFFFFFF`, `IN_LAST=1`, accepted in cycle 0.
  - Cycle 3: `OUT_VALID=1`, `ACC=0xFFFFFFFE00000001`, `OUT_CNT=1`, `OVF=0`.
- **Four-beat frame.** Beats (3,5), (7,11), (0x10000,0x10000), (0,0xDEAD) with last on the fourth.
  - Result: `ACC=0x10000005C`, `OUT_CNT=4`, arriving 3 cycles after the last beat.
- **Backpressure.** Three 2-beat frames streamed continuously, with `OUT_READY` held 0 for 5 cycles after the first result.
  - `IN_READY` is 0 for exactly those cycles.
  - All three results arrive in order with correct sums.
  - `ACC` is stable while stalled.
- **Overflow.** `ACC_W=64`, two beats of 0xFFFFFFFF×0xFFFFFFFF.
  - Result: `ACC=0xFFFFFFFC00000002`, `OVF=1`.
  - The next frame, (2,3,last), gives `ACC=6`, `OVF=0`.
- **Reset mid-frame.** Two non-last beats accepted, then `RST` for 1 cycle, then (2,3,last).
  - All outputs are 0 during and after reset.
  - The result is `ACC=6`, `OUT_CNT=1`. No stale partial sum remains.
- **Bubbles and counter saturation.**
  - Frame (1,1) ×3 with `IN_VALID` gaps of 2 cycles → `ACC=3`, `OUT_CNT=3`.
  - With `CNT_W=2`, a 5-beat frame → `OUT_CNT=3`, and `ACC` is still exact.

Source files
------------

// File: rtl/vedic_mac_32bits.sv
// Streaming multiply-accumulate stage around the vedic_32bits multiplier:
// operand register, product register, then a frame accumulator with valid/ready output.

module vedic_32bits (
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [63:0] Q
);
    logic [31:0] ll, lh, hl, hh;
    logic [32:0] mid;

    // Urdhva-tiryak on 16-bit halves: vertical terms ll/hh, crosswise terms lh+hl.
    always_comb begin
        ll  = A[15:0]  * B[15:0];
        lh  = A[15:0]  * B[31:16];
        hl  = A[31:16] * B[15:0];
        hh  = A[31:16] * B[31:16];
        mid = {1'b0, lh} + {1'b0, hl};
        Q   = {hh, ll} + {15'b0, mid, 16'b0};
    end
endmodule

module vedic_mac_32bits #(
    parameter int ACC_W = 72,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic             IN_LAST,
    input  logic [31:0]      A,
    input  logic [31:0]      B,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [ACC_W-1:0] ACC,
    output logic [CNT_W-1:0] OUT_CNT,
    output logic             OVF
);
    logic             en;
    logic [31:0]      a_r, b_r;
    logic             last1, v1;
    logic [63:0]      q, p_r;
    logic             last2, v2;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt, cnt_inc;
    logic             ovf_acc;
    logic [ACC_W:0]   sum;
    logic             carry;

    // A stalled result freezes every stage, so no beat can be lost or duplicated.
    assign en       = ~(OUT_VALID & ~OUT_READY);
    assign IN_READY = en;

    vedic_32bits u_mul (
        .A (a_r),
        .B (b_r),
        .Q (q)
    );

    always_comb begin
        sum     = {1'b0, acc} + (ACC_W+1)'(p_r);
        carry   = sum[ACC_W];
        cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            a_r   <= '0;
            b_r   <= '0;
            last1 <= 1'b0;
            v1    <= 1'b0;
            p_r   <= '0;
            last2 <= 1'b0;
            v2    <= 1'b0;
        end else if (en) begin
            a_r   <= A;
            b_r   <= B;
            last1 <= IN_LAST;
            v1    <= IN_VALID;
            p_r   <= q;
            last2 <= last1;
            v2    <= v1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc       <= '0;
            cnt       <= '0;
            ovf_acc   <= 1'b0;
            ACC       <= '0;
            OUT_CNT   <= '0;
            OVF       <= 1'b0;
            OUT_VALID <= 1'b0;
        end else if (en & v2 & last2) begin
            ACC       <= sum[ACC_W-1:0];
            OUT_CNT   <= cnt_inc;
            OVF       <= ovf_acc | carry;
            OUT_VALID <= 1'b1;
            acc       <= '0;
            cnt       <= '0;
            ovf_acc   <= 1'b0;
        end else begin
            if (en & v2) begin
                acc     <= sum[ACC_W-1:0];
                cnt     <= cnt_inc;
                ovf_acc <= ovf_acc | carry;
            end
            if (OUT_VALID & OUT_READY)
                OUT_VALID <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vedic_mac_32bits.sv
// Bench for vedic_mac_32bits: a default instance and a 64-bit/2-bit-counter instance
// share stimulus and are checked against a plain frame-sum scoreboard.

module tb_vedic_mac_32bits;
    logic        clk, rst, in_valid, in_last, out_ready;
    logic [31:0] a, b;

    logic        in_ready, out_valid, ovf;
    logic [71:0] acc;
    logic [7:0]  out_cnt;

    logic        in_ready_s, out_valid_s, ovf_s;
    logic [63:0] acc_s;
    logic [1:0]  out_cnt_s;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    typedef struct {
        logic [127:0] sum;
        int unsigned  n;
    } exp_t;

    exp_t         q[$];
    exp_t         e;
    logic [127:0] m_sum;
    int unsigned  m_n;

    logic [127:0] last_acc72, last_acc64;
    int unsigned  last_cnt8, last_cnt2;
    logic         last_ovf72, last_ovf64;

    vedic_mac_32bits dut (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready), .IN_LAST(in_last),
        .A(a), .B(b), .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .ACC(acc), .OUT_CNT(out_cnt), .OVF(ovf)
    );

    vedic_mac_32bits #(.ACC_W(64), .CNT_W(2)) dut_s (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready_s), .IN_LAST(in_last),
        .A(a), .B(b), .OUT_VALID(out_valid_s), .OUT_READY(out_ready),
        .ACC(acc_s), .OUT_CNT(out_cnt_s), .OVF(ovf_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned sat(input int unsigned n, input int unsigned mx);
        return (n > mx) ? mx : n;
    endfunction

    // Scoreboard: sums accepted beats per frame, compares each result as it is consumed.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            m_sum = '0;
            m_n   = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("acc72",  acc,     e.sum & ((128'd1 << 72) - 1));
                    chk("cnt8",   out_cnt, sat(e.n, 255));
                    chk("ovf72",  ovf,     (e.sum >> 72) != 0);
                    chk("valid_s", out_valid_s, 1);
                    chk("acc64",  acc_s,   e.sum & ((128'd1 << 64) - 1));
                    chk("cnt2",   out_cnt_s, sat(e.n, 3));
                    chk("ovf64",  ovf_s,   (e.sum >> 64) != 0);
                    last_acc72 = acc;   last_cnt8 = out_cnt;   last_ovf72 = ovf;
                    last_acc64 = acc_s; last_cnt2 = out_cnt_s; last_ovf64 = ovf_s;
                end
            end
            if (in_valid && in_ready) begin
                m_sum += 128'(a) * 128'(b);
                m_n++;
                if (in_last) begin
                    q.push_back('{m_sum, m_n});
                    m_sum = '0;
                    m_n   = 0;
                end
            end
        end
    end

    task automatic beat(input logic [31:0] av, input logic [31:0] bv, input logic lv);
        bit done = 0;
        a = av; b = bv; in_last = lv; in_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready && !rst) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        if (!done) chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk);
            #1;
            if (q.size() == 0 && !out_valid) done = 1;
        end
        chk("drain", done, 1);
    endtask

    initial begin
        bit seen;
        bit rdone;
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; a = '0; b = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_acc",   acc, 0);
        chk("rst_cnt",   out_cnt, 0);
        chk("rst_ovf",   ovf, 0);
        chk("rst_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // single beat, max operands, 3-cycle latency
        beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        @(negedge clk); chk("lat_c1", out_valid, 0);
        @(negedge clk); chk("lat_c2", out_valid, 0);
        @(negedge clk); chk("lat_c3", out_valid, 1);
        wait_drain();
        chk("max_acc", last_acc72, 128'hFFFF_FFFE_0000_0001);
        chk("max_cnt", last_cnt8, 1);
        chk("max_ovf", last_ovf72, 0);

        // four-beat frame
        beat(3, 5, 0); beat(7, 11, 0); beat(32'h10000, 32'h10000, 0); beat(0, 32'hDEAD, 1);
        wait_drain();
        chk("four_acc", last_acc72, 128'h1_0000_005C);
        chk("four_cnt", last_cnt8, 4);

        // backpressure: first result held for 5 cycles
        seen = 0;
        fork
            begin
                beat(1, 2, 0); beat(3, 4, 1);
                beat(5, 6, 0); beat(7, 8, 1);
                beat(9, 10, 0); beat(11, 12, 1);
            end
            begin
                for (int i = 0; i < 50 && !seen; i++) begin
                    @(posedge clk);
                    #1;
                    if (out_valid) seen = 1;
                end
                chk("bp_first", seen, 1);
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_in_ready", in_ready, 0);
                    chk("bp_stable", acc, 14);
                    chk("bp_valid", out_valid, 1);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
                @(negedge clk);
                chk("bp_release", in_ready, 1);
            end
        join
        wait_drain();
        chk("bp_last", last_acc72, 222);

        // overflow on the 64-bit instance, then a clean frame
        beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0); beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        wait_drain();
        chk("ovf_acc64", last_acc64, 128'hFFFF_FFFC_0000_0002);
        chk("ovf_flag64", last_ovf64, 1);
        chk("ovf_acc72", last_acc72, 128'h1_FFFF_FFFC_0000_0002);
        chk("ovf_flag72", last_ovf72, 0);
        beat(2, 3, 1);
        wait_drain();
        chk("post_ovf_acc", last_acc64, 6);
        chk("post_ovf_flag", last_ovf64, 0);

        // reset mid-frame
        beat(5, 7, 0); beat(9, 9, 0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mrst_valid", out_valid, 0);
        chk("mrst_acc", acc, 0);
        chk("mrst_cnt", out_cnt, 0);
        chk("mrst_ovf", ovf, 0);
        chk("mrst_acc_s", acc_s, 0);
        @(posedge clk);
        #1;
        beat(2, 3, 1);
        wait_drain();
        chk("mrst_res_acc", last_acc72, 6);
        chk("mrst_res_cnt", last_cnt8, 1);

        // bubbles inside a frame, then counter saturation
        beat(1, 1, 0); idle(2); beat(1, 1, 0); idle(2); beat(1, 1, 1);
        wait_drain();
        chk("bub_acc", last_acc72, 3);
        chk("bub_cnt", last_cnt8, 3);
        for (int i = 0; i < 5; i++) beat(i + 1, 3, i == 4);
        wait_drain();
        chk("sat_cnt2", last_cnt2, 3);
        chk("sat_cnt8", last_cnt8, 5);
        chk("sat_acc64", last_acc64, 45);

        // randomized frames with random output backpressure
        rdone = 0;
        fork
            begin
                for (int f = 0; f < 40; f++) begin
                    int unsigned len;
                    len = $urandom_range(1, 6);
                    for (int k = 0; k < int'(len); k++) begin
                        logic [31:0] ra, rb;
                        ra = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
                        rb = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
                        beat(ra, rb, k == int'(len) - 1);
                        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                    end
                end
                rdone = 1;
            end
            begin
                while (!rdone) begin
                    @(posedge clk);
                    #2 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
